// File: rtl/dual_rail_pkg.sv
// Shared types for the dual-rail receiver: the Dual rail pair, the
// receiver FSM encoding and a helper that advances a Dual by one token.
package dual_rail_pkg;

    // One dual-rail bit: a transition on high signals 1, on low signals 0.
    typedef struct packed {
        logic high;
        logic low;
    } dual_t;

    localparam logic ST_COLLECT = 1'b0;
    localparam logic ST_FULL    = 1'b1;

    typedef enum logic {
        COLLECT = ST_COLLECT,
        FULL    = ST_FULL
    } state_t;

    // Returns the rail pair after writing one token of value bit_val:
    // the high rail toggles for a 1, the low rail toggles for a 0.
    function automatic dual_t dual_toggle(input dual_t cur, input logic bit_val);
        dual_t nxt;
        nxt = cur;
        if (bit_val) begin
            nxt.high = ~cur.high;
        end else begin
            nxt.low = ~cur.low;
        end
        return nxt;
    endfunction

endpackage

// File: rtl/dual_rail_sync.sv
// Synchroniser for one Dual rail pair. Both rails get their own
// SYNC_STAGES-deep flop chain; the chain is never reset so it keeps
// flushing metastability while the receiver is held in reset.
module dual_rail_sync
    import dual_rail_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic  clock,
    input  dual_t rail_in,
    output dual_t rail_out
);

    logic [SYNC_STAGES-1:0] high_q;
    logic [SYNC_STAGES-1:0] high_d;
    logic [SYNC_STAGES-1:0] low_q;
    logic [SYNC_STAGES-1:0] low_d;

    // Shift each asynchronous rail one stage deeper per clock.
    always_comb begin
        high_d = {high_q[SYNC_STAGES-2:0], rail_in.high};
        low_d  = {low_q[SYNC_STAGES-2:0],  rail_in.low};
    end

    // Synchroniser flops, deliberately without reset.
    always_ff @(posedge clock) begin
        high_q <= high_d;
        low_q  <= low_d;
    end

    assign rail_out.high = high_q[SYNC_STAGES-1];
    assign rail_out.low  = low_q[SYNC_STAGES-1];

endmodule

// File: rtl/dual_rail_receiver.sv
// Dual-rail to clocked-word receiver.
// Synchronises WIDTH transition-signalled Dual bits, waits until every bit
// has toggled relative to the last consumed rail state, presents the word
// on a valid/ready interface and toggles a 2-phase acknowledge back to the
// self-timed sender. A bit whose both rails toggled drops the word and sets
// the sticky error flag.
// Optional feature: define DUAL_RX_TIMEOUT_EN to build the partial-word
// timeout counter; without it timeout_out is tied to 0.
module dual_rail_receiver
    import dual_rail_pkg::*;
#(
    parameter int WIDTH          = 8,
    parameter int SYNC_STAGES    = 2,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic              clock,
    input  logic              reset,
    input  dual_t [WIDTH-1:0] dual_in,
    output logic              ack_out,
    output logic [WIDTH-1:0]  data_out,
    output logic              valid_out,
    input  logic              ready_in,
    output logic              error_out,
    output logic              timeout_out
);

    if (SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : g_bad_sync
        $error("dual_rail_receiver: SYNC_STAGES must be in 2..4");
    end
    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("dual_rail_receiver: TIMEOUT_CYCLES must be at least 1");
    end

    dual_t [WIDTH-1:0] synced;

    for (genvar g = 0; g < WIDTH; g++) begin : g_sync
        dual_rail_sync #(
            .SYNC_STAGES(SYNC_STAGES)
        ) u_sync (
            .clock    (clock),
            .rail_in  (dual_in[g]),
            .rail_out (synced[g])
        );
    end

    state_t            state_q;
    state_t            state_d;
    dual_t [WIDTH-1:0] ref_q;
    dual_t [WIDTH-1:0] ref_d;
    logic [WIDTH-1:0]  data_q;
    logic [WIDTH-1:0]  data_d;
    logic              valid_q;
    logic              valid_d;
    logic              ack_q;
    logic              ack_d;
    logic              error_q;
    logic              error_d;

    logic [WIDTH-1:0]  arrived;
    logic [WIDTH-1:0]  val;
    logic [WIDTH-1:0]  dbl;
    logic              all_arrived;
    logic              any_arrived;
    logic              any_dbl;

    // Compare the synchronised rails against the last consumed state.
    always_comb begin
        arrived = '0;
        val     = '0;
        dbl     = '0;
        for (int i = 0; i < WIDTH; i++) begin
            arrived[i] = (synced[i] != ref_q[i]);
            val[i]     = (synced[i].high != ref_q[i].high);
            dbl[i]     = (synced[i].high != ref_q[i].high) &&
                         (synced[i].low  != ref_q[i].low);
        end
        all_arrived = &arrived;
        any_arrived = |arrived;
        any_dbl     = |dbl;
    end

    // Collect/full handshake: capture or drop a complete word, then wait
    // for the consumer before collecting again.
    always_comb begin
        state_d = state_q;
        ref_d   = ref_q;
        data_d  = data_q;
        valid_d = valid_q;
        ack_d   = ack_q;
        error_d = error_q;
        case (state_q)
            COLLECT: begin
                if (all_arrived) begin
                    ref_d = synced;
                    ack_d = ~ack_q;
                    if (any_dbl) begin
                        error_d = 1'b1;
                    end else begin
                        data_d  = val;
                        valid_d = 1'b1;
                        state_d = FULL;
                    end
                end
            end
            FULL: begin
                if (valid_q && ready_in) begin
                    valid_d = 1'b0;
                    state_d = COLLECT;
                end
            end
            default: begin
                state_d = COLLECT;
            end
        endcase
    end

    // Receiver state; reset keeps re-basing the reference on the rails.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= COLLECT;
            ref_q   <= synced;
            data_q  <= '0;
            valid_q <= 1'b0;
            ack_q   <= 1'b0;
            error_q <= 1'b0;
        end else begin
            state_q <= state_d;
            ref_q   <= ref_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            ack_q   <= ack_d;
            error_q <= error_d;
        end
    end

`ifdef DUAL_RX_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT_CYCLES);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             timeout_q;
    logic             timeout_d;

    // Count cycles a word sits partially arrived; saturate at the limit.
    always_comb begin
        cnt_d     = '0;
        timeout_d = timeout_q;
        if (state_q == COLLECT && any_arrived && !all_arrived) begin
            cnt_d = cnt_q;
            if (cnt_q != CNT_LIMIT) begin
                cnt_d = cnt_q + CNT_W'(1);
            end
            if (cnt_d == CNT_LIMIT) begin
                timeout_d = 1'b1;
            end
        end
    end

    // Timeout counter and sticky flag.
    always_ff @(posedge clock) begin
        if (reset) begin
            cnt_q     <= '0;
            timeout_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            timeout_q <= timeout_d;
        end
    end

    assign timeout_out = timeout_q;
`else
    assign timeout_out = 1'b0;
`endif

    assign ack_out   = ack_q;
    assign data_out  = data_q;
    assign valid_out = valid_q;
    assign error_out = error_q;

endmodule
